// File: rtl/hex_key_pkg.sv
// Shared types and constants for the hex_key_ctrl push-button digit controller.
package hex_key_pkg;

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop synchroniser -> debounced level and one-cycle press pulse.
module key_debounce
  import hex_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(DEBOUNCE_CYCLES);

  // sync[1] is the synchronised key, sync[2] its value one cycle earlier
  logic [2:0]       sync;
  logic [1:0]       vld;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;
  logic             armed;

  // run_cnt: consecutive cycles the synchronised key has held its value, saturating at STABLE
  always_comb begin
    run_nxt = run_cnt;
    if (!vld[1])
      run_nxt = '0;
    else if (sync[1] != sync[2])
      run_nxt = CNT_W'(1);
    else if (run_cnt != STABLE)
      run_nxt = run_cnt + CNT_W'(1);
  end

  // A press only counts once a settled release has been seen since reset,
  // so a key held through reset stays silent until released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '1;
      vld       <= '0;
      run_cnt   <= '0;
      key_level <= 1'b1;
      armed     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync    <= {sync[1:0], key_raw};
      vld     <= {vld[0], 1'b1};
      run_cnt <= run_nxt;
      press   <= 1'b0;
      if (run_nxt == STABLE) begin
        if (sync[1] != key_level) begin
          key_level <= sync[1];
          press     <= armed & key_level;
        end else if (key_level) begin
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hex_key_ctrl.sv
// STEP/RUN hex digit controller driven by three debounced keys.
// Optional auto-repeat in STEP when HEX_KEY_AUTOREPEAT_EN is defined.
module hex_key_ctrl
  import hex_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_PERIOD      = 25000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  output logic [3:0] digit,
  output logic       running,
  output logic       dir_up,
  output logic [6:0] HEX
);

  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RUN_PERIOD - 1);

  logic [2:0]       lvl;
  logic [2:0]       prs;
  logic             lvl_unused;
  state_t           state;
  state_t           state_nxt;
  logic [3:0]       digit_nxt;
  logic             dir_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_nxt;
  logic             up_evt;
  logic             dn_evt;
  logic             rpt_step;
  logic             rpt_up;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key0 (
    .clk(clk), .rst(rst), .key_raw(key0), .key_level(lvl[0]), .press(prs[0])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key1 (
    .clk(clk), .rst(rst), .key_raw(key1), .key_level(lvl[1]), .press(prs[1])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key2 (
    .clk(clk), .rst(rst), .key_raw(key2), .key_level(lvl[2]), .press(prs[2])
  );

  assign lvl_unused = ^lvl;

`ifdef HEX_KEY_AUTOREPEAT_EN
  localparam int unsigned      RPT_FAST   = (RUN_PERIOD / 4 == 0) ? 1 : RUN_PERIOD / 4;
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(RUN_PERIOD - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RUN_PERIOD - RPT_FAST);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_hold;

  // Exactly one of key0/key1 held in STEP; any press restarts the delay
  assign rpt_hold = (state == ST_STEP) && (lvl[0] ^ lvl[1]) && !(|prs);
  assign rpt_up   = !lvl[0];
  assign rpt_step = rpt_hold && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rpt_cnt <= '0;
    else if (!rpt_hold)
      rpt_cnt <= '0;
    else if (rpt_step)
      rpt_cnt <= RPT_RELOAD;
    else
      rpt_cnt <= rpt_cnt + CNT_W'(1);
  end
`else
  assign rpt_step = 1'b0;
  assign rpt_up   = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    dir_nxt   = dir_up;
    per_nxt   = per_cnt;
    up_evt    = prs[0] & ~prs[1];
    dn_evt    = prs[1] & ~prs[0];
    unique case (state)
      ST_STEP: begin
        per_nxt = '0;
        if (prs[2])
          state_nxt = ST_RUN;
        else if (up_evt)
          digit_nxt = digit + 4'd1;
        else if (dn_evt)
          digit_nxt = digit - 4'd1;
        else if (rpt_step)
          digit_nxt = rpt_up ? digit + 4'd1 : digit - 4'd1;
      end
      ST_RUN: begin
        if (prs[2]) begin
          state_nxt = ST_STEP;
          per_nxt   = '0;
        end else begin
          // terminal step reads the current dir_up, so a same-cycle key press only affects later steps
          if (per_cnt == PER_LAST) begin
            per_nxt   = '0;
            digit_nxt = dir_up ? digit + 4'd1 : digit - 4'd1;
          end else begin
            per_nxt = per_cnt + CNT_W'(1);
          end
          if (up_evt)
            dir_nxt = 1'b1;
          else if (dn_evt)
            dir_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_STEP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_STEP;
      digit   <= '0;
      dir_up  <= 1'b1;
      per_cnt <= '0;
    end else begin
      state   <= state_nxt;
      digit   <= digit_nxt;
      dir_up  <= dir_nxt;
      per_cnt <= per_nxt;
    end
  end

  assign running = (state == ST_RUN);
  assign HEX     = SEG_TABLE[digit];

endmodule

// File: tb/tb_hex_key_ctrl.sv
// Scoreboard bench for hex_key_ctrl with DEBOUNCE_CYCLES=4, RUN_PERIOD=8.
module tb_hex_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key0, key1, key2;
  logic [3:0] digit;
  logic       running;
  logic       dir_up;
  logic [6:0] HEX;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  prev_digit = 4'd0;

  hex_key_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_PERIOD(8), .CNT_W(25)) dut (
    .clk(clk), .rst(rst), .key0(key0), .key1(key1), .key2(key2),
    .digit(digit), .running(running), .dir_up(dir_up), .HEX(HEX)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every digit change must match the next queued expectation
  always @(negedge clk) begin
    if (digit !== prev_digit) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_step", 32'(digit), 32'(prev_digit));
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check_val("digit", 32'(digit), 32'(e));
        check_val("hex", 32'(HEX), 32'(glyph(e)));
      end
      prev_digit = digit;
    end
  end

  task automatic tap(input int k);
    if (k == 0) key0 = 1'b0; else if (k == 1) key1 = 1'b0; else key2 = 1'b0;
    repeat (10) @(negedge clk);
    key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_change(input int budget, output int cyc);
    logic [3:0] d0;
    d0  = digit;
    cyc = 0;
    while (digit === d0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check_val("change_seen", 32'(digit !== d0), 32'd1);
  endtask

  task automatic wait_running(input logic val, input int budget);
    int c = 0;
    while (running !== val && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val("running", 32'(running), 32'(val));
  endtask

  task automatic wait_dir(input logic val, input int budget);
    int c = 0;
    while (dir_up !== val && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val("dir_up", 32'(dir_up), 32'(val));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_digit", 32'(digit), 32'd0);
    check_val("rst_hex", 32'(HEX), 32'b1000000);
    check_val("rst_running", 32'(running), 32'd0);
    check_val("rst_dir", 32'(dir_up), 32'd1);
    repeat (10) @(negedge clk);

    // glitches shorter than the debounce window, then one real press
    for (int g = 0; g < 3; g++) begin
      key0 = 1'b0; repeat (3) @(negedge clk);
      key0 = 1'b1; repeat (2) @(negedge clk);
    end
    exp_q.push_back(4'h1);
    key0 = 1'b0; repeat (10) @(negedge clk);
    key0 = 1'b1; repeat (12) @(negedge clk);
    check_val("glitch_q", 32'(exp_q.size()), 32'd0);
    check_val("glitch_hex", 32'(HEX), 32'b1111001);

    // 1 -> 0 -> F -> 0 in STEP
    exp_q.push_back(4'h0); tap(1);
    exp_q.push_back(4'hF); tap(1);
    check_val("wrap_dn_hex", 32'(HEX), 32'b0001110);
    exp_q.push_back(4'h0); tap(0);

    // RUN: count up every 8 cycles
    key2 = 1'b0;
    wait_running(1'b1, 30);
    key2 = 1'b1;
    exp_q.push_back(4'h1); wait_change(20, cyc); check_val("run_period", 32'(cyc), 32'd8);
    exp_q.push_back(4'h2); wait_change(20, cyc); check_val("run_period", 32'(cyc), 32'd8);
    key1 = 1'b0;
    wait_dir(1'b0, 20);
    exp_q.push_back(4'h1);
    key1 = 1'b1;
    wait_change(20, cyc);
    exp_q.push_back(4'h0); wait_change(20, cyc); check_val("run_period_dn", 32'(cyc), 32'd8);
    exp_q.push_back(4'hF); wait_change(20, cyc); check_val("run_wrap", 32'(cyc), 32'd8);
    key2 = 1'b0;
    wait_running(1'b0, 20);
    key2 = 1'b1;
    repeat (40) @(negedge clk);
    check_val("frozen", 32'(digit), 32'hF);
    check_val("frozen_q", 32'(exp_q.size()), 32'd0);

    // key0 + key2 together from digit 3: only the toggle
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(4'(i));
      tap(0);
    end
    key0 = 1'b0; key2 = 1'b0;
    wait_running(1'b1, 30);
    check_val("simul_digit", 32'(digit), 32'd3);
    check_val("simul_dir", 32'(dir_up), 32'd0);
    exp_q.push_back(4'h2);
    key0 = 1'b1; key2 = 1'b1;
    wait_change(20, cyc);
    check_val("simul_period", 32'(cyc), 32'd8);
    key2 = 1'b0;
    wait_running(1'b0, 20);
    key2 = 1'b1;
    repeat (12) @(negedge clk);

    // key0 + key1 together in STEP: no change
    key0 = 1'b0; key1 = 1'b0;
    repeat (10) @(negedge clk);
    key0 = 1'b1; key1 = 1'b1;
    repeat (12) @(negedge clk);
    check_val("both_digit", 32'(digit), 32'd2);

    // reset mid-period in RUN with key0 held
    key2 = 1'b0;
    wait_running(1'b1, 30);
    key2 = 1'b1;
    repeat (3) @(negedge clk);
    key0 = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(4'h0);
    rst = 1'b1;
    #1;
    check_val("mid_rst_digit", 32'(digit), 32'd0);
    check_val("mid_rst_hex", 32'(HEX), 32'b1000000);
    check_val("mid_rst_running", 32'(running), 32'd0);
    check_val("mid_rst_dir", 32'(dir_up), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_val("held_no_evt", 32'(digit), 32'd0);
    key0 = 1'b1;
    repeat (15) @(negedge clk);
    exp_q.push_back(4'h1);
    tap(0);

    check_val("q_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
